// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state, decoder enable triples and the active-low hex segment table.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

    // Enable inputs of the 3-to-8 decoder: G1 (active high), /G2, /G3.
    typedef struct packed {
        logic g1;
        logic g2_n;
        logic g3_n;
    } dec_en_t;

    localparam dec_en_t DEC_ON    = '{g1: 1'b1, g2_n: 1'b0, g3_n: 1'b0};
    localparam dec_en_t DEC_BLANK = '{g1: 1'b0, g2_n: 1'b0, g3_n: 1'b0};
    localparam dec_en_t DEC_OFF   = '{g1: 1'b0, g2_n: 1'b1, g3_n: 1'b1};

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Segments {g,f,e,d,c,b,a}, active low; entry 15 first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // True when digit idx (>0) and every higher scanned digit hold zero.
    function automatic logic lz_blank(input logic [31:0] digits,
                                      input logic [2:0]  idx,
                                      input int unsigned ndig);
        logic all_zero;
        all_zero = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k >= 32'(idx) && k < ndig && digits[4*k +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        return (idx != 3'd0) && all_zero;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the scan controller: digit data/mask/enable in,
// decoder select/enables, segment bus and frame tick out.
interface seg_scan_ctrl_if;

    logic        en;
    logic [31:0] digits_i;
    logic [7:0]  dp_i;
    logic [7:0]  digit_mask;

    logic        sel_c;
    logic        sel_b;
    logic        sel_a;
    logic        dec_g1;
    logic        dec_g2_n;
    logic        dec_g3_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    modport master (
        output en, digits_i, dp_i, digit_mask,
        input  sel_c, sel_b, sel_a, dec_g1, dec_g2_n, dec_g3_n,
               seg_n, dp_n, frame_tick
    );

    modport slave (
        input  en, digits_i, dp_i, digit_mask,
        output sel_c, sel_b, sel_a, dec_g1, dec_g2_n, dec_g3_n,
               seg_n, dp_n, frame_tick
    );

endinterface

// File: rtl/hex7seg_n.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex7seg_n
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_TABLE[nib_i];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark leading zeros above digit 0).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 1000,
    parameter int unsigned BLANK_CYC = 4,
    parameter int unsigned DIGITS    = 8
) (
    input logic            clk,
    input logic            rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned     CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nib_q, nib_d;
    logic             dpsn_q, dpsn_d;
    logic             slot_wrap;
`ifdef LEADING_ZERO_BLANK_EN
    logic             lzb_q, lzb_d;
`endif

    logic [2:0]       sel_q, sel_d;
    dec_en_t          dec_q, dec_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             tick_q, tick_d;

    logic [6:0]       seg_hex;

    hex7seg_n u_hex7seg (
        .nib_i   (nib_q),
        .seg_n_o (seg_hex)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            nib_q   <= '0;
            dpsn_q  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            lzb_q   <= 1'b0;
`endif
            sel_q   <= '0;
            dec_q   <= DEC_OFF;
            seg_q   <= SEG_OFF;
            dp_n_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            dpsn_q  <= dpsn_d;
`ifdef LEADING_ZERO_BLANK_EN
            lzb_q   <= lzb_d;
`endif
            sel_q   <= sel_d;
            dec_q   <= dec_d;
            seg_q   <= seg_d;
            dp_n_q  <= dp_n_d;
            tick_q  <= tick_d;
        end
    end

    // cnt runs 0..CLK_DIV-1 over the whole slot; BLANK covers its first BLANK_CYC counts.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nib_d     = nib_q;
        dpsn_d    = dpsn_q;
`ifdef LEADING_ZERO_BLANK_EN
        lzb_d     = lzb_q;
`endif
        slot_wrap = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        nib_d  = bus.digits_i[{idx_q, 2'b00} +: 4];
                        dpsn_d = bus.dp_i[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
                        lzb_d  = lz_blank(bus.digits_i, idx_q, DIGITS);
`endif
                    end
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            slot_wrap = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs follow the current state one edge later, so sel and the
    // segment bus always switch together with dec_g1 dropping to 0.
    always_comb begin
        sel_d  = idx_q;
        dec_d  = DEC_OFF;
        seg_d  = SEG_OFF;
        dp_n_d = 1'b1;
        tick_d = slot_wrap;
        case (state_q)
            BLANK: begin
                dec_d = DEC_BLANK;
            end
            SHOW: begin
                dec_d    = DEC_BLANK;
                dec_d.g1 = bus.digit_mask[idx_q];
                seg_d    = seg_hex;
                dp_n_d   = ~dpsn_q;
`ifdef LEADING_ZERO_BLANK_EN
                if (lzb_q) begin
                    seg_d  = SEG_OFF;
                    dp_n_d = 1'b1;
                end
`endif
            end
            default: begin
                sel_d = '0;
            end
        endcase
    end

    assign {bus.sel_c, bus.sel_b, bus.sel_a} = sel_q;
    assign bus.dec_g1     = dec_q.g1;
    assign bus.dec_g2_n   = dec_q.g2_n;
    assign bus.dec_g3_n   = dec_q.g3_n;
    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: time-based scan model compared every
// cycle, plus hand-computed expectations at fixed points of the run.
module tb_seg_scan_ctrl;

    localparam int unsigned CLK_DIV   = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned DIGITS    = 8;

    logic clk = 1'b0;
    logic rst_n;

    seg_scan_ctrl_if bus_if ();

    seg_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .DIGITS    (DIGITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned b        = 0;

    // Output vector: {sel[2:0], g1, g2_n, g3_n, seg_n[6:0], dp_n, frame_tick}
    logic [14:0] dut_v;
    assign dut_v = {bus_if.sel_c, bus_if.sel_b, bus_if.sel_a, bus_if.dec_g1,
                    bus_if.dec_g2_n, bus_if.dec_g3_n, bus_if.seg_n,
                    bus_if.dp_n, bus_if.frame_tick};

    localparam logic [14:0] RESET_V = {3'd0, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0};

    function automatic logic [14:0] pack(input logic [2:0] s, input logic g1,
                                         input logic g2n, input logic g3n,
                                         input logic [6:0] seg, input logic dpn,
                                         input logic tk);
        return {s, g1, g2n, g3n, seg, dpn, tk};
    endfunction

    function automatic logic [6:0] hexseg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic at(input int unsigned k);
        while (cyc < b + k) @(negedge clk);
    endtask

    // Scan model: the scan is a free-running time index since enable;
    // slot, digit and phase follow by division.
    bit          m_act   = 1'b0;
    bit          m_valid = 1'b0;
    int unsigned m_t     = 0;
    int unsigned m_idx, m_ph;
    logic [14:0] m_exp;
    logic        m_tk, m_dpn;
    logic [6:0]  m_seg;
    logic [3:0]  snib   [8];
    logic        sdp    [8];
    logic        sblank [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            snib[i] = 4'h0; sdp[i] = 1'b0; sblank[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            m_idx = (m_t / CLK_DIV) % DIGITS;
            m_ph  = m_t % CLK_DIV;
            if (!rst_n || !m_act) begin
                m_exp = RESET_V;
            end else begin
                m_tk = bus_if.en && (m_ph == CLK_DIV - 1) && (m_idx == DIGITS - 1);
                if (m_ph >= BLANK_CYC) begin
                    m_seg = hexseg(snib[m_idx]);
                    m_dpn = ~sdp[m_idx];
                    if (sblank[m_idx]) begin
                        m_seg = 7'h7F;
                        m_dpn = 1'b1;
                    end
                    m_exp = pack(3'(m_idx), bus_if.digit_mask[m_idx], 1'b0, 1'b0, m_seg, m_dpn, m_tk);
                end else begin
                    m_exp = pack(3'(m_idx), 1'b0, 1'b0, 1'b0, 7'h7F, 1'b1, m_tk);
                end
            end
            if (rst_n && bus_if.en && m_act && m_ph == 0) begin
                snib[m_idx]   = bus_if.digits_i[4*m_idx +: 4];
                sdp[m_idx]    = bus_if.dp_i[m_idx];
                sblank[m_idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                if (m_idx > 0) begin
                    sblank[m_idx] = 1'b1;
                    for (int unsigned k = m_idx; k < DIGITS; k++) begin
                        if (bus_if.digits_i[4*k +: 4] != 4'h0) sblank[m_idx] = 1'b0;
                    end
                end
`endif
            end
            if (!rst_n || !bus_if.en) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                m_act = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            m_valid = 1'b1;
            @(negedge clk);
            if (m_valid) check("scan_model", dut_v, m_exp);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    logic [6:0]  lz_seg;
    int unsigned ticks;

    initial begin
        rst_n             = 1'b0;
        bus_if.en         = 1'b1;
        bus_if.digits_i   = 32'hFEDCBA98;
        bus_if.dp_i       = 8'h00;
        bus_if.digit_mask = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_values", dut_v, RESET_V);
        b     = cyc;
        rst_n = 1'b1;

        at(3);  check("slot0_blank", dut_v, pack(3'd0, 1'b0, 1'b0, 1'b0, 7'h7F, 1'b1, 1'b0));
        at(4);  check("slot0_show",  dut_v, pack(3'd0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0));
        at(60); check("slot7_show",  dut_v, pack(3'd7, 1'b1, 1'b0, 1'b0, 7'h0E, 1'b1, 1'b0));

        ticks = 0;
        for (int unsigned k = 61; k <= 129; k++) begin
            at(k);
            if (bus_if.frame_tick) ticks++;
            if (k == 65) check("tick_edge", dut_v, pack(3'd7, 1'b1, 1'b0, 1'b0, 7'h0E, 1'b1, 1'b1));
        end
        check("frame_ticks", 15'(ticks), 15'd2);

        bus_if.digit_mask = 8'hFE;
        bus_if.dp_i       = 8'h02;
        at(132); check("mask_slot0", dut_v, pack(3'd0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0));
        at(140); check("dp_slot1",   dut_v, pack(3'd1, 1'b1, 1'b0, 1'b0, 7'h10, 1'b0, 1'b0));

        at(141);
        bus_if.digits_i   = 32'h00000000;
        bus_if.digit_mask = 8'hFF;
        bus_if.dp_i       = 8'h00;
        at(157);
        bus_if.digits_i   = 32'h00008000;
        at(161); check("snap_hold",  dut_v, pack(3'd3, 1'b1, 1'b0, 1'b0, 7'h40, 1'b1, 1'b0));
        at(220); check("snap_next",  dut_v, pack(3'd3, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0));

        at(221);
        bus_if.en = 1'b0;
        at(222); check("dis_lag",    dut_v, pack(3'd3, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0));
        at(223); check("dis_idle",   dut_v, RESET_V);
        at(225);
        bus_if.en = 1'b1;
        at(228); check("reen_blank", dut_v, pack(3'd0, 1'b0, 1'b0, 1'b0, 7'h7F, 1'b1, 1'b0));
        at(229); check("reen_show",  dut_v, pack(3'd0, 1'b1, 1'b0, 1'b0, 7'h40, 1'b1, 1'b0));

        at(233);
        rst_n           = 1'b0;
        bus_if.digits_i = 32'h00000105;
        at(234); check("mid_reset",  dut_v, RESET_V);
        at(235);
        rst_n = 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
        lz_seg = 7'h7F;
`else
        lz_seg = 7'h40;
`endif
        at(239); check("lz_d0", dut_v, pack(3'd0, 1'b1, 1'b0, 1'b0, 7'h12, 1'b1, 1'b0));
        at(247); check("lz_d1", dut_v, pack(3'd1, 1'b1, 1'b0, 1'b0, 7'h40, 1'b1, 1'b0));
        at(255); check("lz_d2", dut_v, pack(3'd2, 1'b1, 1'b0, 1'b0, 7'h79, 1'b1, 1'b0));
        at(263); check("lz_d3", dut_v, pack(3'd3, 1'b1, 1'b0, 1'b0, lz_seg, 1'b1, 1'b0));
        at(295); check("lz_d7", dut_v, pack(3'd7, 1'b1, 1'b0, 1'b0, lz_seg, 1'b1, 1'b0));

        at(305);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
